// File: rtl/risc32_uart_tx_pkg.sv
// risc32_uart_tx_pkg: UART register offsets, status bit positions and FSM state encodings
package risc32_uart_tx_pkg;
    localparam logic [1:0] UART_OFS_DATA   = 2'd0;
    localparam logic [1:0] UART_OFS_STATUS = 2'd1;
    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_e;
    function automatic logic [31:0] status_word(input logic full, input logic empty,
                                                input logic busy, input logic ovf);
        logic [31:0] s;
        s = '0;
        s[STAT_FULL]  = full;
        s[STAT_EMPTY] = empty;
        s[STAT_BUSY]  = busy;
        s[STAT_OVF]   = ovf;
        return s;
    endfunction
endpackage

// File: rtl/risc32_uart_fifo.sv
// risc32_uart_fifo: byte FIFO with wrap-bit pointers and combinational head output
module risc32_uart_fifo
    import risc32_uart_tx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wp;
    logic [AW:0] rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty = wp == rp;
    assign dout  = mem[rp[AW-1:0]];
    // pointers advance only on accepted operations so they can never pass each other
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
    // storage needs no reset; only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/risc32_uart_tx.sv
// risc32_uart_tx: memory-mapped UART transmitter with FIFO; define RISC32_UART_PARITY_EN for 8E1
module risc32_uart_tx
    import risc32_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    output logic        busy_o
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
`ifdef RISC32_UART_PARITY_EN
    localparam uart_state_e AFTER_DATA = S_PARITY;
`else
    localparam uart_state_e AFTER_DATA = S_STOP;
`endif
    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          ovf_q;
    logic          tick, pop, full, empty, wr_data, rd_stat;
    logic [7:0]    dout;
    logic          unused_bits;
    assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:8]};
    assign wr_data = ce_i && we_i && addr_i[3:2] == UART_OFS_DATA;
    assign rd_stat = ce_i && !we_i && addr_i[3:2] == UART_OFS_STATUS;
    assign tick    = cnt_q == CW'(DIV - 1);
    assign busy_o  = state_q != S_IDLE || !empty;
    assign tx_o    = tx_q;
    assign data_o  = rd_stat ? status_word(full, empty, busy_o, ovf_q) : '0;

    risc32_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_data),
        .pop   (pop),
        .din   (data_i[7:0]),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    // frame state, baud/bit counters and the line driver are registered together
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    // overflow is sticky until a status read; a new drop in the read cycle wins
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= (wr_data && full) || (ovf_q && !rd_stat);
    end

    // next-state, counter and pop decisions; counter restarts on every state entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        pop     = 1'b0;
        tx_d    = state_q == S_START  ? 1'b0 :
                  state_q == S_DATA   ? sh_q[bit_q] :
                  state_q == S_PARITY ? ^sh_q : 1'b1;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = dout;
                    state_d = S_START;
                end
            end
            S_START: if (tick) begin
                cnt_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: if (tick) begin
                cnt_d = '0;
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    bit_d   = '0;
                    state_d = AFTER_DATA;
                end
            end
            S_PARITY: if (tick) begin
                cnt_d   = '0;
                state_d = S_STOP;
            end
            S_STOP: if (tick) begin
                cnt_d   = '0;
                state_d = empty ? S_IDLE : S_START;
                pop     = !empty;
                sh_d    = empty ? sh_q : dout;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_risc32_uart_tx.sv
// tb_risc32_uart_tx: directed checks of the UART transmitter at DIV=16; define RISC32_UART_PARITY_EN for 8E1
module tb_risc32_uart_tx;
    localparam int DIV = 16;
`ifdef RISC32_UART_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB = PAR ? 11 : 10;
    localparam int FL = NB * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        tx_o;
    logic        busy_o;
    int          checks = 0;
    int          errors = 0;

    risc32_uart_tx #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .ce_i   (ce_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .data_i (data_i),
        .data_o (data_o),
        .tx_o   (tx_o),
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        int i;
        i = k / DIV;
        return i == 0 ? 1'b0 : i <= 8 ? b[i-1] : (PAR && i == 9) ? ^b : 1'b1;
    endfunction

    task automatic bus_write(input logic [7:0] b);
        ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h0; data_i = {24'hABCDEF, b};
        @(posedge clk);
        @(negedge clk);
        ce_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic read_status(input logic [31:0] exp, input string name);
        ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h4;
        #1;
        checks++;
        if (data_o !== exp) begin
            errors++;
            $display("FAIL %s: data_o=%h expected %h", name, data_o, exp);
        end
        @(posedge clk);
        @(negedge clk);
        ce_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_frame(input logic [7:0] b, input string name);
        int bad;
        int first;
        bad = 0;
        first = -1;
        @(negedge clk);
        checks++;
        if (tx_o !== 1'b1) begin
            errors++;
            $display("FAIL %s pre-start: tx_o=%b expected 1", name, tx_o);
        end
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            if (tx_o !== frame_bit(b, k)) begin
                bad++;
                if (first < 0) first = k;
            end
            if (k == FL / 2) begin
                checks++;
                if (busy_o !== 1'b1) begin
                    errors++;
                    $display("FAIL %s mid busy: busy_o=%b expected 1", name, busy_o);
                end
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s waveform: %0d wrong cycles (first at %0d) expected 0", name, bad, first);
        end
        @(negedge clk);
        checks++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s end: tx_o=%b busy_o=%b expected 1 0", name, tx_o, busy_o);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset outputs: tx=%b busy=%b data_o=%h expected 1 0 0", tx_o, busy_o, data_o);
        end
        read_status(32'h2, "reset status");
    endtask

    task automatic test_decode();
        logic [31:0] addrs [4] = '{32'h0, 32'h8, 32'h4, 32'h4};
        logic        ces   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic        wes   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            ce_i = ces[i]; we_i = wes[i]; addr_i = addrs[i]; data_i = 32'h5A;
            #1;
            checks++;
            if (data_o !== 32'h0) begin
                errors++;
                $display("FAIL decode %0d: data_o=%h expected 0", i, data_o);
            end
            @(posedge clk);
            @(negedge clk);
        end
        ce_i = 1'b0; we_i = 1'b1; addr_i = 32'h0;
        @(posedge clk);
        @(negedge clk);
        we_i = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL decode idle: tx=%b busy=%b expected 1 0", tx_o, busy_o);
        end
        read_status(32'h2, "decode fifo empty");
    endtask

    task automatic test_frame_55();
        bus_write(8'h55);
        check_frame(8'h55, "frame 0x55");
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3] = '{8'h01, 8'h02, 8'h03};
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int i = 0; i < 3; i++) bus_write(bytes[i]);
        for (int k = 0; k < 3 * FL; k++) begin
            if (k > 0) @(negedge clk);
            if (tx_o !== frame_bit(bytes[k / FL], k % FL)) begin
                bad++;
                if (first < 0) first = k;
            end
            if (k == 3 * FL - 10) begin
                checks++;
                if (busy_o !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b busy in 3rd stop: busy_o=%b expected 1", busy_o);
                end
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL b2b stream: %0d wrong cycles (first at %0d) expected 0", bad, first);
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || tx_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b end: busy_o=%b tx=%b expected 0 1", busy_o, tx_o);
        end
    endtask

    task automatic test_overflow();
        bus_write(8'h11);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 17; i++) bus_write(8'(i));
        read_status(32'h0000000D, "overflow status");
        read_status(32'h00000005, "overflow cleared");
        do_reset();
        read_status(32'h2, "overflow after reset");
    endtask

    task automatic test_reset_mid_frame();
        int toggles;
        toggles = 0;
        bus_write(8'hA5);
        repeat (40) @(negedge clk);
        checks++;
        if (tx_o !== 1'b0) begin
            errors++;
            $display("FAIL midframe data bit1: tx_o=%b expected 0", tx_o);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx_o !== 1'b1) begin
            errors++;
            $display("FAIL midframe reset tx: tx_o=%b expected 1", tx_o);
        end
        rst = 1'b0;
        read_status(32'h2, "midframe status");
        for (int k = 0; k < 2 * FL; k++) begin
            @(negedge clk);
            if (tx_o !== 1'b1 || busy_o !== 1'b0) toggles++;
        end
        checks++;
        if (toggles !== 0) begin
            errors++;
            $display("FAIL midframe quiet: %0d active cycles expected 0", toggles);
        end
    endtask

`ifdef RISC32_UART_PARITY_EN
    task automatic test_parity();
        bus_write(8'h07);
        check_frame(8'h07, "parity 0x07");
        bus_write(8'h03);
        check_frame(8'h03, "parity 0x03");
    endtask
`endif

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_decode();
        test_frame_55();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
`ifdef RISC32_UART_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
